// File: rtl/ex_mem_reg_if.sv
// EX/MEM boundary bundle: the EX-side handshake and payload plus the MEM-side
// handshake and payload. The slave modport is the pipeline register; master is its surroundings.
interface ex_mem_reg_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  ex_valid;
  logic                  ex_ready;
  logic [DATA_WIDTH-1:0] ex_alu_result;
  logic [DATA_WIDTH-1:0] ex_store_data;
  logic [DATA_WIDTH-1:0] ex_pc_plus4;
  logic [DATA_WIDTH-1:0] ex_branch_target;
  logic [4:0]            ex_rd;
  logic [2:0]            ex_funct3;
  logic                  ex_reg_write;
  logic                  ex_mem_read;
  logic                  ex_mem_write;
  logic                  ex_branch;
  logic [1:0]            ex_wb_sel;

  logic                  mem_ready;
  logic                  mem_valid;
  logic [DATA_WIDTH-1:0] mem_alu_result;
  logic [DATA_WIDTH-1:0] mem_store_data;
  logic [DATA_WIDTH-1:0] mem_pc_plus4;
  logic [4:0]            mem_rd;
  logic [2:0]            mem_funct3;
  logic [1:0]            mem_wb_sel;
  logic                  mem_reg_write;
  logic                  mem_mem_read;
  logic                  mem_mem_write;

  modport master (
    output ex_valid, ex_alu_result, ex_store_data, ex_pc_plus4, ex_branch_target,
           ex_rd, ex_funct3, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_wb_sel,
    input  ex_ready,
    output mem_ready,
    input  mem_valid, mem_alu_result, mem_store_data, mem_pc_plus4, mem_rd, mem_funct3,
           mem_wb_sel, mem_reg_write, mem_mem_read, mem_mem_write
  );

  modport slave (
    input  ex_valid, ex_alu_result, ex_store_data, ex_pc_plus4, ex_branch_target,
           ex_rd, ex_funct3, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_wb_sel,
    output ex_ready,
    input  mem_ready,
    output mem_valid, mem_alu_result, mem_store_data, mem_pc_plus4, mem_rd, mem_funct3,
           mem_wb_sel, mem_reg_write, mem_mem_read, mem_mem_write
  );
endinterface

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with a 2-entry skid buffer, branch resolution,
// load-use hazard reporting and a saturating backpressure counter.
module ex_mem_reg #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  ex_mem_reg_if.slave           bus,
  input  logic                  flush,
  output logic                  redirect_valid,
  output logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  load_pending,
  output logic [4:0]            load_rd,
  output logic [CNT_WIDTH-1:0]  stall_cycles
);

  typedef enum logic [1:0] {
    S_EMPTY,
    S_ONE,
    S_TWO
  } state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] alu_result;
    logic [DATA_WIDTH-1:0] store_data;
    logic [DATA_WIDTH-1:0] pc_plus4;
    logic [4:0]            rd;
    logic [2:0]            funct3;
    logic [1:0]            wb_sel;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
  } payload_t;

  localparam logic [CNT_WIDTH-1:0] STALL_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t   state;
  payload_t out_q;
  payload_t skid_q;
  payload_t in_pl;
  logic     mem_valid_q;
  logic     ready_q;
  logic     acc;
  logic     drn;
  logic     taken;

  always_comb begin
    in_pl            = '0;
    in_pl.alu_result = bus.ex_alu_result;
    in_pl.store_data = bus.ex_store_data;
    in_pl.pc_plus4   = bus.ex_pc_plus4;
    in_pl.rd         = bus.ex_rd;
    in_pl.funct3     = bus.ex_funct3;
    in_pl.wb_sel     = bus.ex_wb_sel;
    // Writes to x0 are dropped here so downstream never has to special-case it.
    in_pl.reg_write  = bus.ex_reg_write & (bus.ex_rd != 5'd0);
    in_pl.mem_read   = bus.ex_mem_read;
    in_pl.mem_write  = bus.ex_mem_write;
  end

  assign acc   = bus.ex_valid & ready_q & ~flush;
  assign drn   = mem_valid_q & bus.mem_ready;
  assign taken = bus.ex_branch & bus.ex_alu_result[0];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= S_EMPTY;
      mem_valid_q    <= 1'b0;
      ready_q        <= 1'b1;
      // NOTE: payload registers are reset too because mem_* must read zero in reset.
      out_q          <= '0;
      skid_q         <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      stall_cycles   <= '0;
    end else begin
      redirect_valid <= acc & taken;
      if (acc & taken) redirect_pc <= bus.ex_branch_target;

      if (mem_valid_q & ~bus.mem_ready & (stall_cycles != STALL_MAX))
        stall_cycles <= stall_cycles + CNT_ONE;

      if (flush) begin
        state       <= S_EMPTY;
        mem_valid_q <= 1'b0;
        ready_q     <= 1'b1;
      end else begin
        case (state)
          S_EMPTY: begin
            if (acc) begin
              out_q       <= in_pl;
              state       <= S_ONE;
              mem_valid_q <= 1'b1;
            end
          end
          S_ONE: begin
            if (acc && drn) begin
              out_q <= in_pl;
            end else if (acc) begin
              skid_q  <= in_pl;
              state   <= S_TWO;
              ready_q <= 1'b0;
            end else if (drn) begin
              state       <= S_EMPTY;
              mem_valid_q <= 1'b0;
            end
          end
          S_TWO: begin
            // ex_ready is low here, so only a drain can move the state.
            if (drn) begin
              out_q   <= skid_q;
              state   <= S_ONE;
              ready_q <= 1'b1;
            end
          end
          default: begin
            state       <= S_EMPTY;
            mem_valid_q <= 1'b0;
            ready_q     <= 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.ex_ready       = ready_q;
  assign bus.mem_valid      = mem_valid_q;
  assign bus.mem_alu_result = out_q.alu_result;
  assign bus.mem_store_data = out_q.store_data;
  assign bus.mem_pc_plus4   = out_q.pc_plus4;
  assign bus.mem_rd         = out_q.rd;
  assign bus.mem_funct3     = out_q.funct3;
  assign bus.mem_wb_sel     = out_q.wb_sel;
  assign bus.mem_reg_write  = out_q.reg_write;
  assign bus.mem_mem_read   = out_q.mem_read;
  assign bus.mem_mem_write  = out_q.mem_write;

  assign load_pending = mem_valid_q & out_q.mem_read;
  assign load_rd      = out_q.rd;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Self-checking bench for ex_mem_reg: queue scoreboard checked every cycle,
// a table of single-transaction vectors and hand-written multi-cycle sequences.
module tb_ex_mem_reg;
  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          redirect_valid;
  logic [DW-1:0] redirect_pc;
  logic          load_pending;
  logic [4:0]    load_rd;
  logic [CW-1:0] stall_cycles;

  ex_mem_reg_if #(.DATA_WIDTH(DW)) bus ();

  ex_mem_reg #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus.slave),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .load_pending   (load_pending),
    .load_rd        (load_rd),
    .stall_cycles   (stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] alu;
    logic [DW-1:0] sd;
    logic [DW-1:0] pc4;
    logic [4:0]    rd;
    logic [2:0]    f3;
    logic [1:0]    wb;
    logic          rw;
    logic          mr;
    logic          mw;
  } exp_t;

  typedef struct {
    logic [4:0]    rd;
    logic          rw;
    logic          mr;
    logic          br;
    logic [DW-1:0] alu;
    logic [DW-1:0] tgt;
    logic          exp_rw;
    logic          exp_lp;
    logic          exp_redir;
  } vec_t;

  exp_t          sb[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  logic [CW-1:0] m_stall  = '0;
  logic          m_redir  = 1'b0;
  logic [DW-1:0] m_redir_pc = '0;
  logic          m_acc    = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [DW-1:0] alu, input logic [4:0] rd, input logic rw,
                       input logic mr, input logic br, input logic [DW-1:0] tgt);
    bus.ex_valid         = 1'b1;
    bus.ex_alu_result    = alu;
    bus.ex_store_data    = alu ^ 32'hA5A5_0000;
    bus.ex_pc_plus4      = alu + 32'd4;
    bus.ex_branch_target = tgt;
    bus.ex_rd            = rd;
    bus.ex_funct3        = alu[2:0];
    bus.ex_reg_write     = rw;
    bus.ex_mem_read      = mr;
    bus.ex_mem_write     = ~rw & ~mr & ~br;
    bus.ex_branch        = br;
    bus.ex_wb_sel        = mr ? 2'b01 : ((rd == 5'd1) ? 2'b10 : 2'b00);
  endtask

  task automatic idle();
    bus.ex_valid = 1'b0;
  endtask

  function automatic exp_t make_exp();
    exp_t e;
    e.alu = bus.ex_alu_result;
    e.sd  = bus.ex_store_data;
    e.pc4 = bus.ex_pc_plus4;
    e.rd  = bus.ex_rd;
    e.f3  = bus.ex_funct3;
    e.wb  = bus.ex_wb_sel;
    e.rw  = bus.ex_reg_write & (bus.ex_rd != 5'd0);
    e.mr  = bus.ex_mem_read;
    e.mw  = bus.ex_mem_write;
    return e;
  endfunction

  // One clock: compare outputs against the model at the falling edge, then
  // advance the model with the inputs the DUT is about to sample.
  task automatic step();
    logic drn;
    @(negedge clk);
    check("mem_valid", bus.mem_valid, sb.size() > 0);
    check("ex_ready", bus.ex_ready, sb.size() < 2);
    check("redirect_valid", redirect_valid, m_redir);
    if (m_redir) check("redirect_pc", redirect_pc, m_redir_pc);
    check("stall_cycles", stall_cycles, m_stall);
    check("load_pending", load_pending, (sb.size() > 0) && sb[0].mr);
    if (sb.size() > 0) begin
      check("mem_alu_result", bus.mem_alu_result, sb[0].alu);
      check("mem_store_data", bus.mem_store_data, sb[0].sd);
      check("mem_pc_plus4", bus.mem_pc_plus4, sb[0].pc4);
      check("mem_rd", bus.mem_rd, sb[0].rd);
      check("load_rd", load_rd, sb[0].rd);
      check("mem_funct3", bus.mem_funct3, sb[0].f3);
      check("mem_wb_sel", bus.mem_wb_sel, sb[0].wb);
      check("mem_reg_write", bus.mem_reg_write, sb[0].rw);
      check("mem_mem_write", bus.mem_mem_write, sb[0].mw);
    end
    m_acc = bus.ex_valid & (sb.size() < 2) & ~flush;
    drn   = (sb.size() > 0) & bus.mem_ready;
    if ((sb.size() > 0) && !bus.mem_ready && (m_stall != '1)) m_stall = m_stall + CW'(1);
    m_redir = m_acc & bus.ex_branch & bus.ex_alu_result[0];
    if (m_redir) m_redir_pc = bus.ex_branch_target;
    if (drn) void'(sb.pop_front());
    if (flush) sb.delete();
    else if (m_acc) sb.push_back(make_exp());
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    sb.delete();
    m_stall = '0;
    m_redir = 1'b0;
    m_acc   = 1'b0;
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{rd: 5'd0, rw: 1, mr: 0, br: 0, alu: 32'h10,        tgt: 32'h0,   exp_rw: 0, exp_lp: 0, exp_redir: 0};
    vecs[1] = '{rd: 5'd5, rw: 1, mr: 1, br: 0, alu: 32'h1000,      tgt: 32'h0,   exp_rw: 1, exp_lp: 1, exp_redir: 0};
    vecs[2] = '{rd: 5'd3, rw: 1, mr: 0, br: 0, alu: 32'h2468,      tgt: 32'h0,   exp_rw: 1, exp_lp: 0, exp_redir: 0};
    vecs[3] = '{rd: 5'd0, rw: 0, mr: 0, br: 1, alu: 32'h1,         tgt: 32'h100, exp_rw: 0, exp_lp: 0, exp_redir: 1};
    vecs[4] = '{rd: 5'd0, rw: 0, mr: 0, br: 1, alu: 32'h0,         tgt: 32'h200, exp_rw: 0, exp_lp: 0, exp_redir: 0};
    vecs[5] = '{rd: 5'd0, rw: 0, mr: 0, br: 1, alu: 32'h2,         tgt: 32'h300, exp_rw: 0, exp_lp: 0, exp_redir: 0};
    vecs[6] = '{rd: 5'd7, rw: 1, mr: 0, br: 1, alu: 32'hFFFF_FFFF, tgt: 32'h400, exp_rw: 1, exp_lp: 0, exp_redir: 1};
    vecs[7] = '{rd: 5'd0, rw: 1, mr: 1, br: 0, alu: 32'h3000,      tgt: 32'h0,   exp_rw: 0, exp_lp: 1, exp_redir: 0};

    reset         = 1'b0;
    flush         = 1'b0;
    bus.mem_ready = 1'b0;
    drive(32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0);
    idle();

    // Reset values while held in reset.
    repeat (2) @(posedge clk);
    #2;
    check("rst_mem_valid", bus.mem_valid, 1'b0);
    check("rst_ex_ready", bus.ex_ready, 1'b1);
    check("rst_stall", stall_cycles, '0);
    check("rst_redirect", redirect_valid, 1'b0);
    check("rst_alu_result", bus.mem_alu_result, '0);
    check("rst_redirect_pc", redirect_pc, '0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Fill OUT and SKID, the second one a taken branch, then reset mid-flight.
    drive(32'h11, 5'd2, 1'b1, 1'b0, 1'b0, 32'h0);
    step();
    drive(32'h21, 5'd0, 1'b0, 1'b0, 1'b1, 32'h880);
    step();
    idle();
    #2;
    reset = 1'b0;
    #1;
    check("midrst_mem_valid", bus.mem_valid, 1'b0);
    check("midrst_ex_ready", bus.ex_ready, 1'b1);
    check("midrst_stall", stall_cycles, '0);
    check("midrst_redirect", redirect_valid, 1'b0);
    check("midrst_alu_result", bus.mem_alu_result, '0);
    check("midrst_redirect_pc", redirect_pc, '0);
    model_reset();
    @(posedge clk);
    #2;
    reset = 1'b1;
    @(posedge clk);
    #1;
    step();
    step();
    drive(32'h77, 5'd9, 1'b1, 1'b0, 1'b0, 32'h0);
    step();
    idle();
    #2;
    check("first_accept_latency", bus.mem_alu_result, 32'h77);
    bus.mem_ready = 1'b1;
    step();

    // Table of single transactions: x0 suppression, load hazard, branch decision.
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].alu, vecs[i].rd, vecs[i].rw, vecs[i].mr, vecs[i].br, vecs[i].tgt);
      step();
      idle();
      #2;
      check($sformatf("vec%0d_reg_write", i), bus.mem_reg_write, vecs[i].exp_rw);
      check($sformatf("vec%0d_load_pending", i), load_pending, vecs[i].exp_lp);
      check($sformatf("vec%0d_load_rd", i), load_rd, vecs[i].rd);
      check($sformatf("vec%0d_redirect", i), redirect_valid, vecs[i].exp_redir);
      if (vecs[i].exp_redir) check($sformatf("vec%0d_redirect_pc", i), redirect_pc, vecs[i].tgt);
      step();
      check($sformatf("vec%0d_redirect_drop", i), redirect_valid, 1'b0);
    end

    // Streaming at full rate.
    for (int i = 1; i <= 4; i++) begin
      drive(DW'(i), 5'(i), 1'b1, 1'b0, 1'b0, 32'h0);
      step();
    end
    idle();
    repeat (2) step();

    // Backpressure: A and B buffered, C held upstream until a drain frees SKID.
    bus.mem_ready = 1'b0;
    drive(32'hA, 5'd10, 1'b1, 1'b0, 1'b0, 32'h0);
    step();
    drive(32'hB, 5'd11, 1'b1, 1'b1, 1'b0, 32'h0);
    step();
    check("bp_ready_low", bus.ex_ready, 1'b0);
    drive(32'hC, 5'd12, 1'b1, 1'b0, 1'b0, 32'h0);
    step();
    step();
    check("bp_stall_count", stall_cycles, CW'(3));
    check("bp_out_held", bus.mem_alu_result, 32'hA);
    bus.mem_ready = 1'b1;
    m_acc = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (m_acc) break;
    end
    check("bp_c_accepted", m_acc, 1'b1);
    idle();
    repeat (3) step();

    // Flush in TWO while a taken branch is presented.
    bus.mem_ready = 1'b0;
    drive(32'h31, 5'd4, 1'b1, 1'b0, 1'b0, 32'h0);
    step();
    drive(32'h32, 5'd5, 1'b1, 1'b0, 1'b0, 32'h0);
    step();
    drive(32'h1, 5'd0, 1'b0, 1'b0, 1'b1, 32'h500);
    flush = 1'b1;
    step();
    flush = 1'b0;
    idle();
    #2;
    check("flush2_mem_valid", bus.mem_valid, 1'b0);
    check("flush2_ex_ready", bus.ex_ready, 1'b1);
    check("flush2_redirect", redirect_valid, 1'b0);
    repeat (2) step();

    // Flush in ONE coinciding with a drain and a presented taken branch.
    bus.mem_ready = 1'b1;
    drive(32'h41, 5'd6, 1'b1, 1'b0, 1'b0, 32'h0);
    step();
    drive(32'h3, 5'd0, 1'b0, 1'b0, 1'b1, 32'h600);
    flush = 1'b1;
    step();
    flush = 1'b0;
    idle();
    #2;
    check("flush1_mem_valid", bus.mem_valid, 1'b0);
    check("flush1_redirect", redirect_valid, 1'b0);
    step();
    drive(32'h51, 5'd8, 1'b1, 1'b1, 1'b0, 32'h0);
    step();
    idle();
    repeat (2) step();

    // Counter saturation with a long stall.
    bus.mem_ready = 1'b0;
    drive(32'h61, 5'd9, 1'b1, 1'b0, 1'b0, 32'h0);
    step();
    idle();
    repeat (20) step();
    check("stall_saturated", stall_cycles, {CW{1'b1}});
    bus.mem_ready = 1'b1;
    repeat (2) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
